// File: rtl/exec_muldiv_unit_pkg.sv
// Shared execution-stage definitions: integer opcodes and the MUL/DIV FSM state type.
package exec_pkg;
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_MUL = 4'b0011;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0100;
    localparam logic [OP_W-1:0] OP_MOD = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;
endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Request/response handshake bundle between the issue logic and the MUL/DIV unit.
interface exec_muldiv_unit_if
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/exec_muldiv_unit_step.sv
// One iteration of shift-add multiply or restoring divide on the (acc, shreg) pair.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_is_div,
    output logic [WIDTH:0]   o_acc_c,
    output logic [WIDTH-1:0] o_shreg_c
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;

    always_comb begin
        o_acc_c   = i_acc;
        o_shreg_c = i_shreg;
        w_sum     = '0;
        w_rem_sh  = '0;
        if (i_is_div) begin
            // Remainder shifts left taking the next dividend bit; quotient bit enters shreg LSB.
            w_rem_sh = {i_acc[WIDTH-1:0], i_shreg[WIDTH-1]};
            if (w_rem_sh >= {1'b0, i_b}) begin
                o_acc_c   = w_rem_sh - {1'b0, i_b};
                o_shreg_c = {i_shreg[WIDTH-2:0], 1'b1};
            end else begin
                o_acc_c   = w_rem_sh;
                o_shreg_c = {i_shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Product high half accumulates in acc; low half shifts into shreg from the top.
            w_sum     = i_shreg[0] ? (i_acc + {1'b0, i_b}) : i_acc;
            o_acc_c   = {1'b0, w_sum[WIDTH:1]};
            o_shreg_c = {w_sum[0], i_shreg[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative MUL/DIV/MOD unit, one result bit per cycle, fixed WIDTH+1 cycle latency.
// Define EXEC_MULDIV_SIGNED_EN for two's-complement operands.
module exec_muldiv_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    exec_muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_b;
    logic [TAG_W-1:0] r_tag;
    logic             r_dz;
    logic             r_ill;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
`ifdef EXEC_MULDIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
`endif

    logic             w_accept;
    logic             w_last;
    logic             w_is_div;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == BUSY) && (r_cnt == CNT_W'(1));
    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_MOD);

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_tag    = r_out_tag;
    assign bus.out_err    = r_out_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)    w_state_nxt = BUSY;
            BUSY:    if (w_last)          w_state_nxt = DONE;
            DONE:    if (bus.out_ready)   w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes captured at accept; sign is restored on the final edge.
    always_comb begin
        w_a_mag = bus.in_a;
        w_b_mag = bus.in_b;
`ifdef EXEC_MULDIV_SIGNED_EN
        if (bus.in_a[WIDTH-1]) w_a_mag = -bus.in_a;
        if (bus.in_b[WIDTH-1]) w_b_mag = -bus.in_b;
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_shreg   (r_shreg),
        .i_b       (r_b),
        .i_is_div  (w_is_div),
        .o_acc_c   (w_acc_nxt),
        .o_shreg_c (w_shreg_nxt)
    );

    // Final result selection; divide-by-zero MOD naturally yields the dividend.
    always_comb begin
        w_q = w_shreg_nxt;
        w_r = w_acc_nxt[WIDTH-1:0];
`ifdef EXEC_MULDIV_SIGNED_EN
        if (r_neg_q) w_q = -w_shreg_nxt;
        if (r_neg_r) w_r = -w_acc_nxt[WIDTH-1:0];
`endif
        case (r_op)
            OP_MUL:  w_res = w_q;
            OP_DIV:  w_res = r_dz ? '1 : w_q;
            OP_MOD:  w_res = w_r;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_acc        <= '0;
            r_shreg      <= '0;
            r_b          <= '0;
            r_tag        <= '0;
            r_dz         <= 1'b0;
            r_ill        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_out_err    <= 1'b0;
`ifdef EXEC_MULDIV_SIGNED_EN
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_W'(WIDTH);
                r_op    <= bus.in_op;
                r_acc   <= '0;
                r_shreg <= w_a_mag;
                r_b     <= w_b_mag;
                r_tag   <= bus.in_tag;
                r_dz    <= ((bus.in_op == OP_DIV) || (bus.in_op == OP_MOD)) && (bus.in_b == '0);
                r_ill   <= !((bus.in_op == OP_MUL) || (bus.in_op == OP_DIV) || (bus.in_op == OP_MOD));
`ifdef EXEC_MULDIV_SIGNED_EN
                r_neg_q <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
                r_neg_r <= bus.in_a[WIDTH-1];
`endif
            end else if (r_state == BUSY) begin
                r_cnt   <= r_cnt - CNT_W'(1);
                r_acc   <= w_acc_nxt;
                r_shreg <= w_shreg_nxt;
                if (w_last) begin
                    r_out_result <= w_res;
                    r_out_tag    <= r_tag;
                    r_out_err    <= r_dz | r_ill;
                end
            end
            r_out_valid <= (w_state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed self-checking bench for exec_muldiv_unit (WIDTH=32, TAG_W=5).
module tb_exec_muldiv_unit;
    import exec_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    exec_muldiv_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    exec_muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one request and waits (bounded) for out_valid; lat counts from the request cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] rtag, output logic err, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res  = bus.out_result;
        rtag = bus.out_tag;
        err  = bus.out_err;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
        logic [31:0] res;
        logic [4:0]  rtag;
        logic        err;
        int          lat;
        do_op(op, a, b, 5'd9, res, rtag, err, lat);
        check({name, ".lat"}, 32'(lat), 32'd33);
        check({name, ".res"}, res, exp_res);
        check({name, ".err"}, 32'(err), 32'(exp_err));
        release_out();
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rtag;
        logic        err;
        int          lat;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset.in_ready",  32'(bus.in_ready),  32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result",    bus.out_result,     32'd0);
        check("reset.err",       32'(bus.out_err),   32'd0);

        // MUL with tag, then latency/tag checks
        do_op(OP_MUL, 32'd7, 32'd6, 5'd3, res, rtag, err, lat);
        check("mul7x6.lat", 32'(lat),  32'd33);
        check("mul7x6.res", res,       32'd42);
        check("mul7x6.tag", 32'(rtag), 32'd3);
        check("mul7x6.err", 32'(err),  32'd0);
        release_out();

        run_op("div100_7",  OP_DIV, 32'd100,        32'd7, 32'd14,         1'b0);
        run_op("mod100_7",  OP_MOD, 32'd100,        32'd7, 32'd2,          1'b0);
        run_op("mulmax_2",  OP_MUL, 32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFE,  1'b0);
        run_op("div5_0",    OP_DIV, 32'd5,          32'd0, 32'hFFFF_FFFF,  1'b1);
        run_op("mod5_0",    OP_MOD, 32'd5,          32'd0, 32'd5,          1'b1);
        run_op("illegal",   4'b0001, 32'd12,        32'd3, 32'd0,          1'b1);

        // Hold the result under backpressure while stray requests arrive
        do_op(OP_DIV, 32'd1000, 32'd10, 5'd17, res, rtag, err, lat);
        check("hold.lat", 32'(lat), 32'd33);
        check("hold.res", res,      32'd100);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_op    = OP_MUL;
            bus.in_a     = 32'd11;
            bus.in_b     = 32'd13;
            bus.in_tag   = 5'd30;
            @(negedge clk);
            check("hold.out_valid", 32'(bus.out_valid), 32'd1);
            check("hold.in_ready",  32'(bus.in_ready),  32'd0);
            check("hold.result",    bus.out_result,     32'd100);
            check("hold.tag",       32'(bus.out_tag),   32'd17);
            check("hold.err",       32'(bus.out_err),   32'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        check("handoff.out_valid", 32'(bus.out_valid), 32'd0);
        check("handoff.in_ready",  32'(bus.in_ready),  32'd1);

`ifdef EXEC_MULDIV_SIGNED_EN
        run_op("sdiv_m7_2",   OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("smod_m7_2",   OP_MOD, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("sdiv_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("smod_min_m1", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
`else
        run_op("udiv_big_2",  OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0);
        run_op("umod_big_2",  OP_MOD, 32'hFFFF_FFF9, 32'd2,         32'd1,         1'b0);
`endif

        // Reset in the middle of a busy operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_MUL;
        bus.in_a     = 32'd100;
        bus.in_b     = 32'd100;
        bus.in_tag   = 5'd21;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst.busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.result",    bus.out_result,     32'd0);
        check("midrst.tag",       32'(bus.out_tag),   32'd0);
        check("midrst.err",       32'(bus.out_err),   32'd0);

        do_op(OP_MUL, 32'd3, 32'd5, 5'd4, res, rtag, err, lat);
        check("postrst.lat", 32'(lat),  32'd33);
        check("postrst.res", res,       32'd15);
        check("postrst.tag", 32'(rtag), 32'd4);
        check("postrst.err", 32'(err),  32'd0);
        release_out();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
